// File: rtl/esn_operand_sequencer_pkg.sv
// Shared types and constants for the ESN operand sequencer.
package esn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RES   = 3'd1,
    ST_INP   = 3'd2,
    ST_BIAS  = 3'd3,
    ST_LEAK  = 3'd4,
    ST_OUT   = 3'd5,
    ST_DRAIN = 3'd6
  } seq_state_e;

  // Bit positions inside the operand-enable / tag vector (active-high here).
  localparam int EN_X1     = 0;
  localparam int EN_X2     = 1;
  localparam int EN_W      = 2;
  localparam int EN_WIN    = 3;
  localparam int EN_WINB   = 4;
  localparam int EN_WOUT   = 5;
  localparam int TAG_FIRST = 6;
  localparam int TAG_LAST  = 7;
  localparam int TAG_OUT   = 8;
  localparam int VEC_W     = 9;

  // Heap output register stage, extra X2 registers in the heap, and the
  // number of idle cycles needed to flush the enable delay line.
  localparam int HEAP_LAT  = 1;
  localparam int X2_EXTRA  = 2;
  localparam int DRAIN_LEN = 4;

endpackage

// File: rtl/esn_operand_sequencer_if.sv
// Control/address bundle between top-level control, ROMs/RAM and the heap.
interface esn_operand_sequencer_if #(
  parameter int N_RES  = 16,
  parameter int STEP_W = 16
);
  localparam int W_AW   = $clog2(N_RES * N_RES);
  localparam int IDX_W  = $clog2(N_RES);
  localparam int X_AW   = $clog2(N_RES + 1);

  logic              start;
  logic [STEP_W-1:0] steps;
  logic              busy;
  logic              done;
  logic [W_AW-1:0]   w_addr;
  logic [IDX_W-1:0]  win_addr;
  logic [IDX_W-1:0]  wout_addr;
  logic [X_AW-1:0]   x_addr;
  logic              x_bank;
  logic              EN_in_X1_n;
  logic              EN_in_X2_n;
  logic              EN_in_W_n;
  logic              EN_in_Win_n;
  logic              EN_in_Winb_n;
  logic              EN_in_Wout_n;
  logic              tag_first;
  logic              tag_last;
  logic              tag_out;

  modport master (
    output start, steps,
    input  busy, done, w_addr, win_addr, wout_addr, x_addr, x_bank,
    input  EN_in_X1_n, EN_in_X2_n, EN_in_W_n, EN_in_Win_n, EN_in_Winb_n, EN_in_Wout_n,
    input  tag_first, tag_last, tag_out
  );

  modport slave (
    input  start, steps,
    output busy, done, w_addr, win_addr, wout_addr, x_addr, x_bank,
    output EN_in_X1_n, EN_in_X2_n, EN_in_W_n, EN_in_Win_n, EN_in_Winb_n, EN_in_Wout_n,
    output tag_first, tag_last, tag_out
  );
endinterface

// File: rtl/esn_operand_sequencer_en_delay.sv
// Delay line for the enable/tag vector. X1/W/Win/Winb/Wout and the tags leave
// at TAP_A; the X2 bit continues through a short tail to TAP_B because the heap
// holds X2 back by additional registers. Enables are inverted to active-low.
module esn_en_delay
  import esn_seq_pkg::*;
#(
  parameter int TAP_A = 2,
  parameter int TAP_B = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [VEC_W-1:0] i_vec,
  output logic             o_en_x1_n,
  output logic             o_en_x2_n,
  output logic             o_en_w_n,
  output logic             o_en_win_n,
  output logic             o_en_winb_n,
  output logic             o_en_wout_n,
  output logic             o_tag_first,
  output logic             o_tag_last,
  output logic             o_tag_out
);
  localparam int TAIL = TAP_B - TAP_A;

  logic [VEC_W-1:0] r_line    [TAP_A];
  logic             r_x2_tail [TAIL];

  // Shift the vector every cycle; reset clears every stage so no stale enable survives.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < TAP_A; k++) r_line[k] <= '0;
      for (int k = 0; k < TAIL; k++)  r_x2_tail[k] <= 1'b0;
    end else begin
      r_line[0] <= i_vec;
      for (int k = 1; k < TAP_A; k++) r_line[k] <= r_line[k-1];
      r_x2_tail[0] <= r_line[TAP_A-1][EN_X2];
      for (int k = 1; k < TAIL; k++)  r_x2_tail[k] <= r_x2_tail[k-1];
    end
  end

  assign o_en_x1_n   = ~r_line[TAP_A-1][EN_X1];
  assign o_en_w_n    = ~r_line[TAP_A-1][EN_W];
  assign o_en_win_n  = ~r_line[TAP_A-1][EN_WIN];
  assign o_en_winb_n = ~r_line[TAP_A-1][EN_WINB];
  assign o_en_wout_n = ~r_line[TAP_A-1][EN_WOUT];
  assign o_tag_first =  r_line[TAP_A-1][TAG_FIRST];
  assign o_tag_last  =  r_line[TAP_A-1][TAG_LAST];
  assign o_tag_out   =  r_line[TAP_A-1][TAG_OUT];
  assign o_en_x2_n   = ~r_x2_tail[TAIL-1];

endmodule

// File: rtl/esn_operand_sequencer.sv
// ESN operand sequencer: walks ROM/RAM addresses for each reservoir time step
// and emits heap operand enables aligned to the read + heap latency.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; steps==0 completes immediately
// ST_RES   | W(i,j) * x(j) operands, N_RES cycles per neuron
// ST_INP   | Win(i) * u operand
// ST_BIAS  | Winb(i) operand, closes the neuron accumulation
// ST_LEAK  | previous state x(i) to the leak path (X2)
// ST_OUT   | Wout(j) * x_new(j) operands for the output layer
// ST_DRAIN | idle cycles flushing the enable delay line, then next step
module esn_operand_sequencer
  import esn_seq_pkg::*;
#(
  parameter int bit_length = 32,
  parameter int N_RES      = 16,
  parameter int STEP_W     = 16,
  parameter int RD_LAT     = 1
) (
  input logic                    clk,
  input logic                    nrst,
  esn_operand_sequencer_if.slave seq_bus
);
  localparam int W_AW  = $clog2(N_RES * N_RES);
  localparam int IDX_W = $clog2(N_RES);
  localparam int X_AW  = $clog2(N_RES + 1);
  localparam int DRN_W = $clog2(DRAIN_LEN);
  localparam int TAP_A = RD_LAT + HEAP_LAT;
  localparam int TAP_B = TAP_A + X2_EXTRA;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RES - 1);

  if (N_RES < 2 || N_RES > 256 || bit_length < 1 || RD_LAT < 1) begin : g_bad_param
    $error("esn_operand_sequencer: illegal parameter value");
  end

  seq_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_i, w_i_nxt;
  logic [IDX_W-1:0]  r_j, w_j_nxt;
  logic [W_AW-1:0]   r_w, w_w_nxt;
  logic [STEP_W-1:0] r_t, w_t_nxt;
  logic [STEP_W-1:0] r_steps, w_steps_nxt;
  logic              r_bank, w_bank_nxt;
  logic [DRN_W-1:0]  r_drain, w_drain_nxt;
  logic              r_done, w_done_nxt;

  logic [VEC_W-1:0]  w_vec;
  logic [W_AW-1:0]   w_w_addr;
  logic [IDX_W-1:0]  w_win_addr;
  logic [IDX_W-1:0]  w_wout_addr;
  logic [X_AW-1:0]   w_x_addr;
  logic              w_x_bank;

  // Next-state, counter updates, issued addresses and the undelayed enable vector.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_w_nxt     = r_w;
    w_t_nxt     = r_t;
    w_steps_nxt = r_steps;
    w_bank_nxt  = r_bank;
    w_drain_nxt = r_drain;
    w_done_nxt  = 1'b0;
    w_vec       = '0;
    w_w_addr    = '0;
    w_win_addr  = '0;
    w_wout_addr = '0;
    w_x_addr    = '0;
    w_x_bank    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (seq_bus.start) begin
          w_steps_nxt = seq_bus.steps;
          w_t_nxt     = '0;
          w_bank_nxt  = 1'b0;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_w_nxt     = '0;
          if (seq_bus.steps == '0) w_done_nxt  = 1'b1;
          else                     w_state_nxt = ST_RES;
        end
      end

      ST_RES: begin
        w_w_addr         = r_w;
        w_x_addr         = X_AW'(r_j);
        w_x_bank         = r_bank;
        w_vec[EN_W]      = 1'b1;
        w_vec[EN_X1]     = 1'b1;
        w_vec[TAG_FIRST] = (r_j == '0);
        // r_w is a flat i*N_RES+j counter; it is cleared rather than allowed to roll over.
        if (r_j == IDX_LAST && r_i == IDX_LAST) w_w_nxt = '0;
        else                                    w_w_nxt = r_w + W_AW'(1);
        if (r_j == IDX_LAST) begin
          w_j_nxt     = '0;
          w_state_nxt = ST_INP;
        end else begin
          w_j_nxt = r_j + IDX_W'(1);
        end
      end

      ST_INP: begin
        w_x_addr      = X_AW'(N_RES);
        w_win_addr    = r_i;
        w_vec[EN_WIN] = 1'b1;
        w_vec[EN_X1]  = 1'b1;
        w_state_nxt   = ST_BIAS;
      end

      ST_BIAS: begin
        w_win_addr      = r_i;
        w_vec[EN_WINB]  = 1'b1;
        w_vec[TAG_LAST] = 1'b1;
        w_state_nxt     = ST_LEAK;
      end

      ST_LEAK: begin
        w_x_addr     = X_AW'(r_i);
        w_x_bank     = r_bank;
        w_vec[EN_X2] = 1'b1;
        w_j_nxt      = '0;
        if (r_i != IDX_LAST) begin
          w_i_nxt     = r_i + IDX_W'(1);
          w_state_nxt = ST_RES;
        end else begin
          w_i_nxt     = '0;
          w_state_nxt = ST_OUT;
        end
      end

      ST_OUT: begin
        w_wout_addr      = r_j;
        w_x_addr         = X_AW'(r_j);
        w_x_bank         = ~r_bank;
        w_vec[EN_WOUT]   = 1'b1;
        w_vec[EN_X1]     = 1'b1;
        w_vec[TAG_OUT]   = 1'b1;
        w_vec[TAG_FIRST] = (r_j == '0);
        w_vec[TAG_LAST]  = (r_j == IDX_LAST);
        if (r_j == IDX_LAST) begin
          w_j_nxt     = '0;
          w_drain_nxt = DRN_W'(DRAIN_LEN - 1);
          w_state_nxt = ST_DRAIN;
        end else begin
          w_j_nxt = r_j + IDX_W'(1);
        end
      end

      ST_DRAIN: begin
        if (r_drain == '0) begin
          w_t_nxt    = r_t + STEP_W'(1);
          w_bank_nxt = ~r_bank;
          w_i_nxt    = '0;
          w_j_nxt    = '0;
          w_w_nxt    = '0;
          if (r_t == r_steps - STEP_W'(1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RES;
          end
        end else begin
          w_drain_nxt = r_drain - DRN_W'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and run counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_w     <= '0;
      r_t     <= '0;
      r_steps <= '0;
      r_bank  <= 1'b0;
      r_drain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_w     <= w_w_nxt;
      r_t     <= w_t_nxt;
      r_steps <= w_steps_nxt;
      r_bank  <= w_bank_nxt;
      r_drain <= w_drain_nxt;
      r_done  <= w_done_nxt;
    end
  end

  logic w_en_x1_n, w_en_x2_n, w_en_w_n, w_en_win_n, w_en_winb_n, w_en_wout_n;
  logic w_tag_first, w_tag_last, w_tag_out;

  esn_en_delay #(
    .TAP_A(TAP_A),
    .TAP_B(TAP_B)
  ) u_en_delay (
    .clk        (clk),
    .nrst       (nrst),
    .i_vec      (w_vec),
    .o_en_x1_n  (w_en_x1_n),
    .o_en_x2_n  (w_en_x2_n),
    .o_en_w_n   (w_en_w_n),
    .o_en_win_n (w_en_win_n),
    .o_en_winb_n(w_en_winb_n),
    .o_en_wout_n(w_en_wout_n),
    .o_tag_first(w_tag_first),
    .o_tag_last (w_tag_last),
    .o_tag_out  (w_tag_out)
  );

  assign seq_bus.busy         = (r_state != ST_IDLE);
  assign seq_bus.done         = r_done;
  assign seq_bus.w_addr       = w_w_addr;
  assign seq_bus.win_addr     = w_win_addr;
  assign seq_bus.wout_addr    = w_wout_addr;
  assign seq_bus.x_addr       = w_x_addr;
  assign seq_bus.x_bank       = w_x_bank;
  assign seq_bus.EN_in_X1_n   = w_en_x1_n;
  assign seq_bus.EN_in_X2_n   = w_en_x2_n;
  assign seq_bus.EN_in_W_n    = w_en_w_n;
  assign seq_bus.EN_in_Win_n  = w_en_win_n;
  assign seq_bus.EN_in_Winb_n = w_en_winb_n;
  assign seq_bus.EN_in_Wout_n = w_en_wout_n;
  assign seq_bus.tag_first    = w_tag_first;
  assign seq_bus.tag_last     = w_tag_last;
  assign seq_bus.tag_out      = w_tag_out;

endmodule

// File: tb/tb_esn_operand_sequencer.sv
// Directed bench for esn_operand_sequencer with N_RES=4: a cycle-accurate
// expected trace is built per run and checked cycle by cycle from a queue.
module tb_esn_operand_sequencer;
  localparam int N    = 4;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic nrst;
  int   checks   = 0;
  int   failures = 0;

  esn_operand_sequencer_if #(.N_RES(N), .STEP_W(16)) bus ();

  esn_operand_sequencer #(
    .bit_length(32),
    .N_RES     (N),
    .STEP_W    (16),
    .RD_LAT    (1)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .seq_bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] w_addr;
    logic [1:0] win_addr;
    logic [1:0] wout_addr;
    logic [2:0] x_addr;
    logic       x_bank;
    logic       x1_n;
    logic       x2_n;
    logic       w_n;
    logic       win_n;
    logic       winb_n;
    logic       wout_n;
    logic       first;
    logic       last;
    logic       out;
  } obs_t;

  obs_t mdl [MAXC];
  obs_t q_exp [$];

  function automatic obs_t idle_rec();
    obs_t r;
    r = '0;
    r.x1_n = 1'b1; r.x2_n = 1'b1; r.w_n = 1'b1;
    r.win_n = 1'b1; r.winb_n = 1'b1; r.wout_n = 1'b1;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.busy      = bus.busy;
    r.done      = bus.done;
    r.w_addr    = bus.w_addr;
    r.win_addr  = bus.win_addr;
    r.wout_addr = bus.wout_addr;
    r.x_addr    = bus.x_addr;
    r.x_bank    = bus.x_bank;
    r.x1_n      = bus.EN_in_X1_n;
    r.x2_n      = bus.EN_in_X2_n;
    r.w_n       = bus.EN_in_W_n;
    r.win_n     = bus.EN_in_Win_n;
    r.winb_n    = bus.EN_in_Winb_n;
    r.wout_n    = bus.EN_in_Wout_n;
    r.first     = bus.tag_first;
    r.last      = bus.tag_last;
    r.out       = bus.tag_out;
    return r;
  endfunction

  task automatic chk_rec(input string tag, input int cyc, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected trace; cycle 0 is the first cycle after the start-sampling edge.
  // Addresses appear in the issue cycle, enables/tags 2 cycles later, X2 4 later.
  task automatic build_run(input int s, output int len);
    int   n;
    logic bank;
    for (int c = 0; c < MAXC; c++) mdl[c] = idle_rec();
    n = 0;
    for (int t = 0; t < s; t++) begin
      bank = (t % 2) == 1;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          mdl[n].busy = 1'b1;
          mdl[n].w_addr = 4'(i * N + j);
          mdl[n].x_addr = 3'(j);
          mdl[n].x_bank = bank;
          mdl[n+2].w_n = 1'b0; mdl[n+2].x1_n = 1'b0;
          if (j == 0) mdl[n+2].first = 1'b1;
          n++;
        end
        mdl[n].busy = 1'b1; mdl[n].x_addr = 3'(N); mdl[n].win_addr = 2'(i);
        mdl[n+2].win_n = 1'b0; mdl[n+2].x1_n = 1'b0;
        n++;
        mdl[n].busy = 1'b1; mdl[n].win_addr = 2'(i);
        mdl[n+2].winb_n = 1'b0; mdl[n+2].last = 1'b1;
        n++;
        mdl[n].busy = 1'b1; mdl[n].x_addr = 3'(i); mdl[n].x_bank = bank;
        mdl[n+4].x2_n = 1'b0;
        n++;
      end
      for (int j = 0; j < N; j++) begin
        mdl[n].busy = 1'b1; mdl[n].wout_addr = 2'(j);
        mdl[n].x_addr = 3'(j); mdl[n].x_bank = ~bank;
        mdl[n+2].wout_n = 1'b0; mdl[n+2].x1_n = 1'b0; mdl[n+2].out = 1'b1;
        if (j == 0)     mdl[n+2].first = 1'b1;
        if (j == N - 1) mdl[n+2].last  = 1'b1;
        n++;
      end
      for (int d = 0; d < 4; d++) begin
        mdl[n].busy = 1'b1;
        n++;
      end
    end
    mdl[n].done = 1'b1;
    len = n;
    for (int c = 0; c <= n + 5; c++) q_exp.push_back(mdl[c]);
  endtask

  // Launch a run and check every cycle against the queued trace. start is
  // re-pulsed (with a different steps value) at cycles inj_a/inj_b; the loop
  // stops early at stop_at when that is non-negative.
  task automatic run(input int s, input int inj_a, input int inj_b, input int stop_at,
                     output int busy_cnt, output int done_cnt, output int pair_cnt);
    int   len;
    int   cyc;
    obs_t exp;
    obs_t obs;
    build_run(s, len);
    busy_cnt = 0; done_cnt = 0; pair_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.steps = 16'(s);
    cyc = 0;
    while (q_exp.size() > 0) begin
      @(negedge clk);
      bus.start = (cyc == inj_a) || (cyc == inj_b);
      if (bus.start) bus.steps = 16'd9;
      exp = q_exp.pop_front();
      obs = sample();
      chk_rec("trace", cyc, obs, exp);
      if (obs.busy) busy_cnt++;
      if (obs.done) done_cnt++;
      if (obs.out && obs.last) pair_cnt++;
      if (cyc == stop_at) break;
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int b, d, p;
    nrst      = 1'b0;
    bus.start = 1'b0;
    bus.steps = '0;
    repeat (3) @(negedge clk);
    chk_rec("reset_state", 0, sample(), idle_rec());
    nrst = 1'b1;
    @(negedge clk);
    chk_rec("idle_after_release", 0, sample(), idle_rec());

    run(1, -1, -1, -1, b, d, p);
    chk_int("busy_cycles_steps1", b, 36);
    chk_int("done_pulses_steps1", d, 1);
    chk_int("out_last_pairs_steps1", p, 1);

    run(3, -1, -1, -1, b, d, p);
    chk_int("busy_cycles_steps3", b, 108);
    chk_int("done_pulses_steps3", d, 1);
    chk_int("out_last_pairs_steps3", p, 3);

    run(0, -1, -1, -1, b, d, p);
    chk_int("busy_cycles_steps0", b, 0);
    chk_int("done_pulses_steps0", d, 1);

    run(1, 5, 20, -1, b, d, p);
    chk_int("busy_cycles_start_ignored", b, 36);
    chk_int("done_pulses_start_ignored", d, 1);

    // Reset during the first RES neuron of step 1.
    run(2, -1, -1, 39, b, d, p);
    chk_int("busy_cycles_before_reset", b, 40);
    nrst = 1'b0;
    #1;
    chk_rec("async_reset_midrun", 0, sample(), idle_rec());
    q_exp.delete();
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_rec("idle_after_midrun_reset", k, sample(), idle_rec());
    end

    run(1, -1, -1, -1, b, d, p);
    chk_int("busy_cycles_after_reset", b, 36);
    chk_int("done_pulses_after_reset", d, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
